// File: rtl/mem_pkg.sv
// Shared data_mem encodings: AddrMode codes, RV32I load/store funct3 values
// and the alignment FSM states. Every data_mem user imports this package.
package mem_pkg;

   localparam logic [3:0] AM_LB  = 4'b0000;
   localparam logic [3:0] AM_LH  = 4'b0001;
   localparam logic [3:0] AM_LW  = 4'b0010;
   localparam logic [3:0] AM_LBU = 4'b0011;
   localparam logic [3:0] AM_LHU = 4'b0100;
   localparam logic [3:0] AM_SB  = 4'b0101;
   localparam logic [3:0] AM_SH  = 4'b0110;
   localparam logic [3:0] AM_SW  = 4'b0111;
   localparam logic [3:0] AM_NOP = 4'b1111;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {IDLE, SPLIT, DONE} lsu_state_e;

   // AM_NOP doubles as the "unsupported funct3" marker.
   function automatic logic [3:0] f3_to_mode(input logic wr, input logic [2:0] f3);
      logic [3:0] m;
      m = AM_NOP;
      if (wr) begin
         case (f3)
            F3_B:    m = AM_SB;
            F3_H:    m = AM_SH;
            F3_W:    m = AM_SW;
            default: m = AM_NOP;
         endcase
      end else begin
         case (f3)
            F3_B:    m = AM_LB;
            F3_H:    m = AM_LH;
            F3_W:    m = AM_LW;
            F3_BU:   m = AM_LBU;
            F3_HU:   m = AM_LHU;
            default: m = AM_NOP;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/lsu_align_if.sv
// Request/response and data_mem port bundle of the load/store alignment unit.
interface lsu_align_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) ();
   logic                  req_valid;
   logic                  req_write;
   logic [2:0]            funct3;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  stall;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  illegal;
   logic [3:0]            mem_AddrMode;
   logic [ADDR_WIDTH-1:0] mem_A;
   logic [DATA_WIDTH-1:0] mem_WD;
   logic [DATA_WIDTH-1:0] mem_RD;

   modport master (
      output req_valid, req_write, funct3, req_addr, req_wdata, mem_RD,
      input  stall, rd_valid, rd_data, illegal, mem_AddrMode, mem_A, mem_WD
   );

   modport slave (
      input  req_valid, req_write, funct3, req_addr, req_wdata, mem_RD,
      output stall, rd_valid, rd_data, illegal, mem_AddrMode, mem_A, mem_WD
   );
endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled load value selected by funct3.
module load_extend
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            funct3_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o
);
   always_comb begin
      data_o = data_i;
      case (funct3_i)
         F3_B:    data_o = {{(DATA_WIDTH-8){data_i[7]}}, data_i[7:0]};
         F3_H:    data_o = {{(DATA_WIDTH-16){data_i[15]}}, data_i[15:0]};
         F3_BU:   data_o = {{(DATA_WIDTH-8){1'b0}}, data_i[7:0]};
         F3_HU:   data_o = {{(DATA_WIDTH-16){1'b0}}, data_i[15:0]};
         default: data_o = data_i;
      endcase
   end
endmodule

// File: rtl/lsu_align.sv
// Load/store alignment: aligned accesses pass straight to data_mem, misaligned
// halfword/word accesses are split into byte accesses while the pipeline stalls.
module lsu_align
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   lsu_align_if.slave bus
);
   lsu_state_e            state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [1:0]            last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [2:0]            f3_q, f3_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] asm_q, asm_d;

   logic [DATA_WIDTH-1:0] ext_data;
   logic [3:0]            req_mode;
   logic                  misaligned;

   logic                  stall, rd_valid, illegal;
   logic [DATA_WIDTH-1:0] rd_data, wd;
   logic [ADDR_WIDTH-1:0] addr_out;
   logic [3:0]            mode;

   load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
      .funct3_i (f3_q),
      .data_i   (asm_q),
      .data_o   (ext_data)
   );

   assign req_mode   = f3_to_mode(bus.req_write, bus.funct3);
   assign misaligned = ((bus.funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                       ((bus.funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'd0));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      f3_d     = f3_q;
      write_d  = write_q;
      asm_d    = asm_q;
      stall    = 1'b0;
      rd_valid = 1'b0;
      rd_data  = '0;
      illegal  = 1'b0;
      mode     = AM_NOP;
      addr_out = '0;
      wd       = '0;
      // Outputs are forced to idle values during reset so a split store stops at once.
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  if (req_mode == AM_NOP) begin
                     illegal = 1'b1;
                  end else if (!misaligned) begin
                     mode     = req_mode;
                     addr_out = bus.req_addr;
                     wd       = bus.req_wdata;
                     if (!bus.req_write) begin
                        rd_valid = 1'b1;
                        rd_data  = bus.mem_RD;
                     end
                  end else begin
                     stall    = 1'b1;
                     addr_out = bus.req_addr;
                     addr_d   = bus.req_addr;
                     wdata_d  = bus.req_wdata;
                     f3_d     = bus.funct3;
                     write_d  = bus.req_write;
                     last_d   = (bus.funct3[1:0] == 2'd1) ? 2'd1 : 2'd3;
                     cnt_d    = 2'd1;
                     state_d  = SPLIT;
                     if (bus.req_write) begin
                        mode  = AM_SB;
                        wd    = DATA_WIDTH'(bus.req_wdata[7:0]);
                        asm_d = '0;
                     end else begin
                        mode  = AM_LBU;
                        asm_d = DATA_WIDTH'(bus.mem_RD[7:0]);
                     end
                  end
               end
            end
            SPLIT: begin
               stall    = 1'b1;
               addr_out = addr_q + ADDR_WIDTH'(cnt_q);
               if (write_q) begin
                  mode = AM_SB;
                  wd   = DATA_WIDTH'(wdata_q[8*cnt_q +: 8]);
               end else begin
                  mode = AM_LBU;
                  asm_d[8*cnt_q +: 8] = bus.mem_RD[7:0];
               end
               if (cnt_q == last_q) state_d = DONE;
               else                 cnt_d   = cnt_q + 2'd1;
            end
            DONE: begin
               rd_valid = !write_q;
               rd_data  = write_q ? '0 : ext_data;
               cnt_d    = 2'd0;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         last_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= 3'd0;
         write_q <= 1'b0;
         asm_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         write_q <= write_d;
         asm_q   <= asm_d;
      end
   end

   assign bus.stall        = stall;
   assign bus.rd_valid     = rd_valid;
   assign bus.rd_data      = rd_data;
   assign bus.illegal      = illegal;
   assign bus.mem_AddrMode = mode;
   assign bus.mem_A        = addr_out;
   assign bus.mem_WD       = wd;
endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a byte-addressed data_mem model
// (combinational read, store on the rising edge).
module tb_lsu_align;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_align_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   lsu_align #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // data_mem model, aliased onto 4 KiB
   logic [7:0]  mem [0:4095];
   logic [11:0] ma;
   logic [7:0]  b0, b1, b2, b3;
   assign ma = bus.mem_A[11:0];
   assign b0 = mem[ma];
   assign b1 = mem[ma + 12'd1];
   assign b2 = mem[ma + 12'd2];
   assign b3 = mem[ma + 12'd3];

   always_comb begin
      bus.mem_RD = 32'h0;
      case (bus.mem_AddrMode)
         AM_LB:   bus.mem_RD = {{24{b0[7]}}, b0};
         AM_LH:   bus.mem_RD = {{16{b1[7]}}, b1, b0};
         AM_LW:   bus.mem_RD = {b3, b2, b1, b0};
         AM_LBU:  bus.mem_RD = {24'h0, b0};
         AM_LHU:  bus.mem_RD = {16'h0, b1, b0};
         default: bus.mem_RD = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      case (bus.mem_AddrMode)
         AM_SB: mem[ma] <= bus.mem_WD[7:0];
         AM_SH: begin
            mem[ma]         <= bus.mem_WD[7:0];
            mem[ma + 12'd1] <= bus.mem_WD[15:8];
         end
         AM_SW: begin
            mem[ma]         <= bus.mem_WD[7:0];
            mem[ma + 12'd1] <= bus.mem_WD[15:8];
            mem[ma + 12'd2] <= bus.mem_WD[23:16];
            mem[ma + 12'd3] <= bus.mem_WD[31:24];
         end
         default: ;
      endcase
   end

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // One request cycle: drive after the edge, settle, log the transaction.
   task automatic cyc(input logic v, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      bus.req_valid = v;
      bus.req_write = w;
      bus.funct3    = f3;
      bus.req_addr  = a;
      bus.req_wdata = d;
      #3;
      $display("t=%0t v=%0d w=%0d f3=%0d addr=%08h wd=%08h | mode=%h A=%08h WD=%08h stall=%0d rdv=%0d rd=%08h ill=%0d",
               $time, v, w, f3, a, d, bus.mem_AddrMode, bus.mem_A, bus.mem_WD,
               bus.stall, bus.rd_valid, bus.rd_data, bus.illegal);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] word;
      rst = 1'b1;
      cyc(0, 0, 3'd0, 32'h0, 32'h0);
      cyc(1, 1, F3_W, 32'h100, 32'h1234_5678);
      chk("rst_stall", {31'h0, bus.stall}, 32'h0);
      chk("rst_rdv",   {31'h0, bus.rd_valid}, 32'h0);
      chk("rst_rd",    bus.rd_data, 32'h0);
      chk("rst_ill",   {31'h0, bus.illegal}, 32'h0);
      chk("rst_mode",  {28'h0, bus.mem_AddrMode}, 32'hF);
      chk("rst_A",     bus.mem_A, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.req_valid = 1'b0;

      // aligned word store then load
      cyc(1, 1, F3_W, 32'h100, 32'hDEAD_BEEF);
      chk("sw_stall", {31'h0, bus.stall}, 32'h0);
      chk("sw_mode",  {28'h0, bus.mem_AddrMode}, 32'h7);
      chk("sw_A",     bus.mem_A, 32'h100);
      cyc(1, 0, F3_W, 32'h100, 32'h0);
      chk("lw_stall", {31'h0, bus.stall}, 32'h0);
      chk("lw_mode",  {28'h0, bus.mem_AddrMode}, 32'h2);
      chk("lw_rdv",   {31'h0, bus.rd_valid}, 32'h1);
      chk("lw_rd",    bus.rd_data, 32'hDEAD_BEEF);

      // aligned byte loads, signed and unsigned
      cyc(1, 1, F3_W, 32'h100, 32'h80FF_FF7F);
      cyc(1, 0, F3_B, 32'h103, 32'h0);
      chk("lb_stall", {31'h0, bus.stall}, 32'h0);
      chk("lb_rd",    bus.rd_data, 32'hFFFF_FF80);
      cyc(1, 0, F3_BU, 32'h103, 32'h0);
      chk("lbu_rd",   bus.rd_data, 32'h0000_0080);

      // no request: idle outputs even with garbage on the request bus
      cyc(0, 1, F3_W, 32'h123, 32'hFFFF_FFFF);
      chk("idle_mode", {28'h0, bus.mem_AddrMode}, 32'hF);
      chk("idle_A",    bus.mem_A, 32'h0);
      chk("idle_WD",   bus.mem_WD, 32'h0);
      chk("idle_rdv",  {31'h0, bus.rd_valid}, 32'h0);

      // misaligned word store split into 4 SB
      cyc(1, 1, F3_W, 32'h200, 32'h0);
      cyc(1, 1, F3_W, 32'h204, 32'h0);
      word = 32'h1122_3344;
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, F3_W, 32'h201, word);
         chk($sformatf("msw_stall%0d", i), {31'h0, bus.stall}, 32'h1);
         chk($sformatf("msw_mode%0d", i),  {28'h0, bus.mem_AddrMode}, 32'h5);
         chk($sformatf("msw_A%0d", i),     bus.mem_A, 32'h201 + i);
         chk($sformatf("msw_WD%0d", i),    bus.mem_WD, (word >> (8 * i)) & 32'hFF);
      end
      cyc(1, 1, F3_W, 32'h201, word);
      chk("msw_done_stall", {31'h0, bus.stall}, 32'h0);
      chk("msw_done_mode",  {28'h0, bus.mem_AddrMode}, 32'hF);
      chk("msw_done_rdv",   {31'h0, bus.rd_valid}, 32'h0);
      cyc(1, 0, F3_W, 32'h200, 32'h0);
      chk("msw_rd200", bus.rd_data, 32'h2233_4400);
      cyc(1, 0, F3_W, 32'h204, 32'h0);
      chk("msw_rd204", bus.rd_data, 32'h0000_0011);

      // misaligned word load reassembles the same bytes
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, F3_W, 32'h201, 32'h0);
         chk($sformatf("mlw_mode%0d", i), {28'h0, bus.mem_AddrMode}, 32'h3);
         chk($sformatf("mlw_A%0d", i),    bus.mem_A, 32'h201 + i);
      end
      cyc(1, 0, F3_W, 32'h201, 32'h0);
      chk("mlw_rdv", {31'h0, bus.rd_valid}, 32'h1);
      chk("mlw_rd",  bus.rd_data, 32'h1122_3344);

      // misaligned halfword loads
      cyc(1, 1, F3_W, 32'h300, 32'h0092_3400);
      for (int i = 0; i < 2; i++) begin
         cyc(1, 0, F3_H, 32'h301, 32'h0);
         chk($sformatf("mlh_stall%0d", i), {31'h0, bus.stall}, 32'h1);
         chk($sformatf("mlh_rdv%0d", i),   {31'h0, bus.rd_valid}, 32'h0);
      end
      cyc(1, 0, F3_H, 32'h301, 32'h0);
      chk("mlh_stall", {31'h0, bus.stall}, 32'h0);
      chk("mlh_rdv",   {31'h0, bus.rd_valid}, 32'h1);
      chk("mlh_rd",    bus.rd_data, 32'hFFFF_9234);
      cyc(1, 0, F3_HU, 32'h301, 32'h0);
      cyc(1, 0, F3_HU, 32'h301, 32'h0);
      cyc(1, 0, F3_HU, 32'h301, 32'h0);
      chk("mlhu_rd", bus.rd_data, 32'h0000_9234);

      // reset in the third cycle of a split store
      cyc(1, 1, F3_W, 32'h400, 32'h0);
      cyc(1, 1, F3_W, 32'h404, 32'h0);
      cyc(1, 1, F3_W, 32'h401, 32'hAABB_CCDD);
      cyc(1, 1, F3_W, 32'h401, 32'hAABB_CCDD);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #3;
      chk("rsplit_mode",  {28'h0, bus.mem_AddrMode}, 32'hF);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.req_valid = 1'b0;
      #3;
      chk("rsplit_stall", {31'h0, bus.stall}, 32'h0);
      chk("rsplit_mode2", {28'h0, bus.mem_AddrMode}, 32'hF);
      chk("rsplit_rdv",   {31'h0, bus.rd_valid}, 32'h0);
      cyc(1, 0, F3_W, 32'h400, 32'h0);
      chk("rsplit_rd400", bus.rd_data, 32'h00CC_DD00);
      cyc(1, 0, F3_W, 32'h404, 32'h0);
      chk("rsplit_rd404", bus.rd_data, 32'h0);

      // unsupported funct3
      cyc(1, 0, 3'd3, 32'h400, 32'h0);
      chk("ill_ld",       {31'h0, bus.illegal}, 32'h1);
      chk("ill_ld_mode",  {28'h0, bus.mem_AddrMode}, 32'hF);
      chk("ill_ld_stall", {31'h0, bus.stall}, 32'h0);
      chk("ill_ld_rdv",   {31'h0, bus.rd_valid}, 32'h0);
      cyc(0, 0, 3'd3, 32'h400, 32'h0);
      chk("ill_pulse",    {31'h0, bus.illegal}, 32'h0);
      cyc(1, 1, 3'd4, 32'h400, 32'hFFFF_FFFF);
      chk("ill_st",       {31'h0, bus.illegal}, 32'h1);
      chk("ill_st_mode",  {28'h0, bus.mem_AddrMode}, 32'hF);
      cyc(1, 0, F3_W, 32'h400, 32'h0);
      chk("ill_mem",      bus.rd_data, 32'h00CC_DD00);
      chk("ill_clear",    {31'h0, bus.illegal}, 32'h0);

      // address wrap at the top of the space
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, F3_W, 32'hFFFF_FFFE, 32'h5566_7788);
         chk($sformatf("wrap_A%0d", i), bus.mem_A, 32'hFFFF_FFFE + i);
      end
      cyc(1, 1, F3_W, 32'hFFFF_FFFE, 32'h5566_7788);
      chk("wrap_done_stall", {31'h0, bus.stall}, 32'h0);
      cyc(1, 0, F3_HU, 32'h0, 32'h0);
      chk("wrap_rd0", bus.rd_data, 32'h0000_5566);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
